// File: rtl/enc8to3_rr_pkg.sv
// Shared constants, FSM state type and slot/bit mapping for the 8-to-3 round-robin encoder
// and the 3-to-8 decoder it mirrors.
package enc8to3_rr_pkg;

  localparam int unsigned NSLOT = 8;
  localparam int unsigned SELW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Slot k lives on request/decode bit 7-k.
  function automatic logic [SELW-1:0] slot_bit(input logic [SELW-1:0] k);
    return SELW'(NSLOT - 1) - k;
  endfunction

endpackage

// File: rtl/enc8to3_rr_dec3to8.sv
// 3-to-8 decoder with enable; output bit 7-w is set, so ordering matches the encoder slots.
module dec3to8
  import enc8to3_rr_pkg::*;
(
  input  logic [SELW-1:0]  w_i,
  input  logic             en_i,
  output logic [NSLOT-1:0] y_o
);

  always_comb begin
    y_o = '0;
    if (en_i) y_o[slot_bit(w_i)] = 1'b1;
  end

endmodule

// File: rtl/enc8to3_rr.sv
// Encodes up to eight pending requests into a 3-bit slot index, handed out one per
// Valid/Ready handshake with round-robin (or fixed-priority) selection.
module enc8to3_rr
  import enc8to3_rr_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NSLOT-1:0] req_i,
  input  logic             en_i,
  input  logic             ready_i,
  output logic [SELW-1:0]  w_o,
  output logic             valid_o,
  output logic [NSLOT-1:0] y_o
);

  state_e           state_q, state_d;
  logic [NSLOT-1:0] pend_q, pend_d;   // indexed by slot, not by req bit
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  w_q, w_d;
  logic             valid_q, valid_d;

  logic [NSLOT-1:0] set_v, clr_v, rem;
  logic             hs;

  // First pending slot at or after start, searching upward modulo NSLOT.
  function automatic logic [SELW-1:0] rr_sel(input logic [NSLOT-1:0] mask,
                                              input logic [SELW-1:0]  start);
    logic [SELW-1:0] idx;
    logic            found;
    rr_sel = start;
    found  = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      idx = start + SELW'(i);
      if (!found && mask[idx]) begin
        rr_sel = idx;
        found  = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ptr_q   <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ptr_d   = ptr_q;
    w_d     = w_q;
    valid_d = valid_q;
    set_v   = '0;
    clr_v   = '0;
    hs      = valid_q & ready_i;

    for (int k = 0; k < NSLOT; k++) begin
      set_v[k] = en_i & req_i[slot_bit(SELW'(k))];
    end
    if (hs) clr_v = NSLOT'(1) << w_q;

    // Same-cycle captures stay out of rem so they wait for the next search.
    rem    = pend_q & ~clr_v;
    pend_d = rem | set_v;

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          w_d     = rr_sel(pend_q, RR_EN ? ptr_q : '0);
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hs) begin
          if (RR_EN) ptr_d = w_q + SELW'(1);
          if (rem != '0) begin
            w_d = rr_sel(rem, RR_EN ? (w_q + SELW'(1)) : '0);
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_o     = w_q;
  assign valid_o = valid_q;

  dec3to8 u_dec (
    .w_i  (w_q),
    .en_i (valid_q),
    .y_o  (y_o)
  );

endmodule

// File: tb/tb_enc8to3_rr.sv
// Directed bench for enc8to3_rr: reset, single grant, round-robin wrap, backpressure,
// set/clear collision, En gating and reset mid-operation.
module tb_enc8to3_rr;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic       ready;
  logic [2:0] w;
  logic       valid;
  logic [7:0] y;

  int total = 0;
  int bad   = 0;

  enc8to3_rr #(.RR_EN(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .en_i    (en),
    .ready_i (ready),
    .w_o     (w),
    .valid_o (valid),
    .y_o     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] exp_w, input logic [7:0] exp_y);
    chk({tag, "_valid"}, {7'b0, valid}, 8'h01);
    chk({tag, "_w"}, {5'b0, w}, {5'b0, exp_w});
    chk({tag, "_y"}, y, exp_y);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {7'b0, valid}, 8'h00);
    chk({tag, "_y"}, y, 8'h00);
  endtask

  initial begin
    rst = 1'b1; req = 8'hFF; en = 1'b1; ready = 1'b0;

    // 1: reset dominates a full request vector
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_w", {5'b0, w}, 8'h00);
      chk_idle("rst");
    end
    rst = 1'b0; req = 8'h00; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("post_rst");
    end

    // 2: single request on slot 2, one-cycle grant two edges after the pulse
    req = 8'h20;
    tick();
    chk_idle("single_capture");
    req = 8'h00;
    tick();
    chk_grant("single", 3'd2, 8'h20);
    tick();
    chk_idle("single_done");

    // 3: round-robin from ptr=0, slots 1 and 3 back-to-back
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'h50;
    tick();
    req = 8'h00;
    tick();
    chk_grant("rr_a", 3'd1, 8'h40);
    tick();
    chk_grant("rr_b", 3'd3, 8'h10);
    tick();
    chk_idle("rr_ab_done");
    // ptr=4: slots 0 and 5 give 5 then wrap to 0
    req = 8'h84;
    tick();
    req = 8'h00;
    tick();
    chk_grant("wrap_a", 3'd5, 8'h04);
    tick();
    chk_grant("wrap_b", 3'd0, 8'h80);
    tick();
    chk_idle("wrap_done");

    // 4: backpressure, ptr=1, slots 2 and 6, slot 0 arrives mid-stall
    ready = 1'b0;
    req = 8'h22;
    tick();
    req = 8'h00;
    tick();
    chk_grant("stall_0", 3'd2, 8'h20);
    for (int i = 0; i < 4; i++) begin
      req = (i == 1) ? 8'h80 : 8'h00;
      tick();
      chk_grant("stall_n", 3'd2, 8'h20);
    end
    req = 8'h00;
    ready = 1'b1;
    tick();
    chk_grant("bp_next", 3'd6, 8'h02);
    tick();
    chk_grant("bp_wrap", 3'd0, 8'h80);
    tick();
    chk_idle("bp_done");

    // 5: slot 4 re-requested in its own handshake cycle is retained
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    chk_grant("coll_first", 3'd4, 8'h08);
    req = 8'h08;
    tick();
    chk_idle("coll_gap");
    req = 8'h00;
    tick();
    chk_grant("coll_again", 3'd4, 8'h08);
    tick();
    chk_idle("coll_done");

    // 6a: En=0 blocks capture
    en = 1'b0;
    req = 8'hFF;
    tick();
    chk_idle("en_off_a");
    tick();
    chk_idle("en_off_b");
    req = 8'h00;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("en_off_after");
    end

    // 6b: reset while three slots pending and a grant is outstanding (ptr=5)
    ready = 1'b0;
    req = 8'h70;
    tick();
    req = 8'h00;
    tick();
    chk_grant("pre_rst", 3'd1, 8'h40);
    rst = 1'b1;
    tick();
    chk("mid_rst_w", {5'b0, w}, 8'h00);
    chk_idle("mid_rst");
    rst = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("after_mid_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc8to3_rr.md
Name: enc8to3_rr

Overview:
- Reverse direction of the processor's 3-to-8 register-select decoding: collects up to eight one-hot request lines and encodes them into a 3-bit index W.
- Presents W one at a time under a Valid/Ready handshake, with round-robin fairness.
- Used where several units (e.g. register-file write requesters, interrupt sources) contend for one 3-bit select field on the control path.
- Bit ordering is shared with the decoder: slot k (W = k) corresponds to Req[7-k]. Req[7] is W=3'b000 and Req[0] is W=3'b111.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, slot 0 highest.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req    input  8  request pulses or levels, one bit per slot (Req[7-k] = slot k).
- En     input  1  capture enable; when 0, Req is ignored that cycle.
- Ready  input  1  consumer accepts W this cycle.
- W      output 3  encoded slot index; registered.
- Valid  output 1  W holds a granted slot; registered.
- Y      output 8  one-hot echo of W in decoder ordering (Y[7-W]=1); all zero when Valid=0.

Behaviour:
- Reset (sampled high at an edge):
  - pending=0, ptr=0, W=0, Valid=0, state=IDLE.
  - Reset mid-handshake drops all pending requests and the current grant; no handshake is counted.
- Pending register, per bit:
  - Set when En=1 and Req bit=1.
  - Cleared when that slot completes a handshake (Valid & Ready and W equals that slot).
  - If set and clear hit the same bit in the same cycle, set wins and the request is retained.
  - Req on an already-pending bit has no further effect; there is no counting.
- Selection function sel(mask, ptr):
  - Search slots ptr, ptr+1, … modulo 8 and take the first slot whose pending bit is 1.
  - RR_EN=0: search always starts at slot 0.
- State IDLE (Valid=0):
  - If pending≠0 at the edge: W←sel(pending, ptr), Valid←1, go to HOLD.
  - Otherwise stay in IDLE.
  - Latency: Req captured at edge N, Valid=1 after edge N+1.
- State HOLD (Valid=1):
  - Ready=0: W and Valid stay stable, and the selection is not recomputed even if a higher-priority request arrives.
  - Ready=1 (handshake):
    - ptr←(W+1) mod 8, wrapping 7→0.
    - rem = pending with the granted bit cleared. Requests captured in this same cycle are excluded from rem and are considered next time.
    - If rem≠0: W←sel(rem, W+1), stay in HOLD. This gives back-to-back grants at one per cycle.
    - Otherwise: Valid←0, W holds its value, go to IDLE.
- Y is derived combinationally from the registered W and Valid only, with no path from Req.
- En=0 blocks capture only. Already-pending requests continue to be served.
- All eight requests pending with Ready tied high: grants cycle 0..7 in ptr order over 8 consecutive cycles, with no starvation.
- ptr is unaffected in IDLE and in RR_EN=0 mode.

Decomposition:
- Shared package holds:
  - Constants NSLOT=8 and SELW=3.
  - State enum {IDLE, HOLD}.
  - A slot-to-Req-bit mapping function (bit = 7-k), shared with decoder users.
- Natural sub-module: dec3to8, instantiated with w=W and En=Valid to produce Y. This reuses the existing decoder and guarantees identical ordering.
- Round-robin search stays inline as a function.

Test Plan:
1. Reset with Req=8'hFF held → W=0, Valid=0, Y=0 through the reset cycles. After release with Req=0, Valid stays 0.
2. Single request:
   - Stimulus: Req=8'b0010_0000 pulsed one cycle with En=1, Ready=1.
   - Response: Valid=1 for exactly one cycle, two edges after the pulse, with W=3'b010 and Y=8'b0010_0000. Then IDLE and ptr=3.
3. Round-robin wrap:
   - Stimulus: from ptr=0, Req=8'b0101_0000 (slots 1, 3), Ready=1.
   - Response: W=1 then W=3 back-to-back, leaving ptr=4.
   - Then pulse Req=8'b1000_0100 (slots 0, 5) → W=5 then W=0 (wrap).
4. Backpressure:
   - Stimulus: slots 2 and 6 pending, Ready=0 for 5 cycles, and slot 0 requested mid-stall.
   - Response: W=2 held stable for 5 cycles. After Ready=1: W=6, then W=0.
5. Set/clear collision:
   - Stimulus: while W=4 is handshaking, pulse Req[3] (slot 4) in the same cycle.
   - Response: slot 4 is granted again later (Valid=1, W=4), not lost.
6. En gating and reset mid-op:
   - Req pulsed with En=0 → no Valid ever.
   - With 3 slots pending and Valid=1, assert Reset one cycle → Valid=0, pending cleared, and no grants afterwards.
